pc_sequencer: RTL

- Control-side counterpart of the PC register/selection mux: generates `selection[1:0]` and `pc_enable` every cycle.
- Runs the boot sequence: fetches the first-instruction address, then loads it.
- Arbitrates sequential fetch, branch/call/return and interrupt entry, including the PC-save handshake before vectoring.
- Sits between the decode/execute control logic, the data-memory port and the PC mux.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer control bundle
// decode/execute, memory and PC-mux side signals
interface pc_sequencer_if;
  logic       stall;
  logic       branch_taken;
  logic       rti;
  logic       irq;
  logic       boot_rd_valid;
  logic       save_ack;
  logic [1:0] selection;
  logic       pc_enable;
  logic       boot_rd_req;
  logic       save_req;
  logic       irq_ack;
  logic       in_isr;
  logic       boot_fault;

  modport master (
    output stall, branch_taken, rti, irq,
    output boot_rd_valid, save_ack,
    input  selection, pc_enable, boot_rd_req,
    input  save_req, irq_ack, in_isr, boot_fault
  );

  modport slave (
    input  stall, branch_taken, rti, irq,
    input  boot_rd_valid, save_ack,
    output selection, pc_enable, boot_rd_req,
    output save_req, irq_ack, in_isr, boot_fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC mux select / load strobe sequencer
// boot fetch, branch/rti, interrupt save and vector
module pc_sequencer #(
  parameter int unsigned BOOT_TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    HOLD,
    BOOT_RD,
    BOOT_LOAD,
    RUN,
    IRQ_SAVE,
    IRQ_VEC,
    FAULT
  } state_t;

  localparam logic [7:0] TO = 8'(BOOT_TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       isr, isr_nx;
  logic [1:0] sel;
  logic       pe, brq, sreq, ack, flt;

  // state, boot counter and isr flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HOLD;
      cnt   <= '0;
      isr   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      isr   <= isr_nx;
    end
  end

  // next state and mux/strobe decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    isr_nx   = isr;
    sel      = 2'b00;
    pe       = 1'b0;
    brq      = 1'b0;
    sreq     = 1'b0;
    ack      = 1'b0;
    flt      = 1'b0;
    unique case (state)
      HOLD: begin
        cnt_nx   = '0;
        state_nx = BOOT_RD;
      end
      BOOT_RD: begin
        brq    = 1'b1;
        cnt_nx = cnt + 8'd1;
        if (bus.boot_rd_valid)
          state_nx = BOOT_LOAD;
        else if (cnt_nx == TO)
          state_nx = FAULT;
      end
      BOOT_LOAD: begin
        sel      = 2'b01;
        pe       = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        if (bus.stall) begin
          pe = 1'b0;
        end else if (bus.rti) begin
          sel    = 2'b11;
          pe     = 1'b1;
          isr_nx = 1'b0;
        end else if (bus.branch_taken) begin
          sel = 2'b11;
          pe  = 1'b1;
        end else if (bus.irq && !isr) begin
          state_nx = IRQ_SAVE;
        end else begin
          pe = 1'b1;
        end
      end
      IRQ_SAVE: begin
        sreq = 1'b1;
        if (bus.save_ack)
          state_nx = IRQ_VEC;
      end
      IRQ_VEC: begin
        sel      = 2'b10;
        pe       = 1'b1;
        ack      = 1'b1;
        isr_nx   = 1'b1;
        state_nx = RUN;
      end
      FAULT: begin
        flt = 1'b1;
      end
      default: begin
        state_nx = HOLD;
      end
    endcase
  end

  assign bus.selection   = sel;
  assign bus.pc_enable   = pe;
  assign bus.boot_rd_req = brq;
  assign bus.save_req    = sreq;
  assign bus.irq_ack     = ack;
  assign bus.in_isr      = isr;
  assign bus.boot_fault  = flt;

endmodule
